// File: rtl/alsu16_pkg.sv
// Shared definitions for the 16-bit arithmetic/logic/shift unit: widths,
// opcode constants and the packed result bundle carried by the output register.
package alsu16_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_INC   = 4'h2,
    OP_DEC   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOT   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_SAR   = 4'hA,
    OP_ROL   = 4'hB,
    OP_ROR   = 4'hC,
    OP_NEG   = 4'hD,
    OP_PASSA = 4'hE,
    OP_PASSB = 4'hF
  } alsu_op_e;

  // Result word plus flags; 18 bits total, matches the output register.
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              cy;
    logic              ov;
  } alsu_out_t;

endpackage

// File: rtl/alsu16_shifter.sv
// Combinational single-bit shifter/rotator for opcodes SHL..ROR.
// Any other opcode yields an all-zero bundle; the top only selects this
// output for the shift opcodes.
module alsu16_shifter
  import alsu16_pkg::*;
(
  input  alsu_op_e          i_op,
  input  logic [DATA_W-1:0] i_a,
  output alsu_out_t         o_out
);

  // Shift/rotate by one; Cy takes the bit pushed out of the word.
  always_comb begin
    o_out = '0;
    case (i_op)
      OP_SHL: begin
        o_out.res = {i_a[DATA_W-2:0], 1'b0};
        o_out.cy  = i_a[DATA_W-1];
        // Doubling overflows exactly when the sign bit would change.
        o_out.ov  = i_a[DATA_W-1] ^ i_a[DATA_W-2];
      end
      OP_SHR: begin
        o_out.res = {1'b0, i_a[DATA_W-1:1]};
        o_out.cy  = i_a[0];
      end
      OP_SAR: begin
        o_out.res = {i_a[DATA_W-1], i_a[DATA_W-1:1]};
        o_out.cy  = i_a[0];
      end
      OP_ROL: begin
        o_out.res = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
        o_out.cy  = i_a[DATA_W-1];
      end
      OP_ROR: begin
        o_out.res = {i_a[0], i_a[DATA_W-1:1]};
        o_out.cy  = i_a[0];
      end
      default: o_out = '0;
    endcase
  end

endmodule

// File: rtl/alsu16_bits.sv
// 16-bit ALU/shifter with a single registered stage: combinational next
// value from the current operands/opcode, captured into one 18-bit register
// (result, carry/borrow, signed overflow). No other state is kept.
module alsu16_bits
  import alsu16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] TuplaA,
  input  logic [DATA_W-1:0] TuplaB,
  input  logic [OP_W-1:0]   Funcion,
  output logic [DATA_W-1:0] Respuesta,
  output logic              Cy,
  output logic              Ov
);

  alsu_op_e          w_op;
  alsu_out_t         w_shift;
  alsu_out_t         w_next;
  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W:0]   w_add;
  logic [DATA_W:0]   w_sub;
  logic              w_add_ov;
  logic              w_sub_ov;
  alsu_out_t         r_out;

  assign w_op = alsu_op_e'(Funcion);

  alsu16_shifter u_shifter (
    .i_op  (w_op),
    .i_a   (TuplaA),
    .o_out (w_shift)
  );

  // Operand steering shared by the adder and subtractor: INC/DEC use a
  // constant 1, NEG is computed as 0 - A.
  always_comb begin
    w_x = TuplaA;
    w_y = TuplaB;
    case (w_op)
      OP_INC, OP_DEC: w_y = 16'h0001;
      OP_NEG: begin
        w_x = '0;
        w_y = TuplaA;
      end
      default: ;
    endcase
  end

  // Bit 16 of the 17-bit add is carry-out; of the 17-bit subtract, borrow.
  assign w_add = {1'b0, w_x} + {1'b0, w_y};
  assign w_sub = {1'b0, w_x} - {1'b0, w_y};

  assign w_add_ov = (w_x[DATA_W-1] == w_y[DATA_W-1]) &&
                    (w_add[DATA_W-1] != w_x[DATA_W-1]);
  assign w_sub_ov = (w_x[DATA_W-1] != w_y[DATA_W-1]) &&
                    (w_sub[DATA_W-1] != w_x[DATA_W-1]);

  // Next-value mux across all opcodes; flags default to zero.
  always_comb begin
    w_next = '0;
    case (w_op)
      OP_ADD, OP_INC: begin
        w_next.res = w_add[DATA_W-1:0];
        w_next.cy  = w_add[DATA_W];
        w_next.ov  = w_add_ov;
      end
      OP_SUB, OP_DEC, OP_NEG: begin
        w_next.res = w_sub[DATA_W-1:0];
        w_next.cy  = w_sub[DATA_W];
        w_next.ov  = w_sub_ov;
      end
      OP_AND:   w_next.res = TuplaA & TuplaB;
      OP_OR:    w_next.res = TuplaA | TuplaB;
      OP_XOR:   w_next.res = TuplaA ^ TuplaB;
      OP_NOT:   w_next.res = ~TuplaA;
      OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: w_next = w_shift;
      OP_PASSA: w_next.res = TuplaA;
      OP_PASSB: w_next.res = TuplaB;
      default:  w_next = '0;
    endcase
  end

  // Output register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) r_out <= '0;
    else        r_out <= w_next;
  end

  assign Respuesta = r_out.res;
  assign Cy        = r_out.cy;
  assign Ov        = r_out.ov;

endmodule

// File: tb/tb_alsu16_bits.sv
// Self-checking bench for alsu16_bits: directed vectors with fixed expected
// values, reset behaviour, then random traffic against an integer-arithmetic
// reference model.
module tb_alsu16_bits;
  import alsu16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] TuplaA;
  logic [15:0] TuplaB;
  logic [3:0]  Funcion;
  logic [15:0] Respuesta;
  logic        Cy;
  logic        Ov;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alsu16_bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .TuplaA    (TuplaA),
    .TuplaB    (TuplaB),
    .Funcion   (Funcion),
    .Respuesta (Respuesta),
    .Cy        (Cy),
    .Ov        (Ov)
  );

  function automatic int to_signed(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  function automatic int wrap16(input int v);
    return ((v % 65536) + 65536) % 65536;
  endfunction

  // Reference: returns {result, cy, ov} computed with plain integer math.
  function automatic logic [17:0] ref_model(input logic [15:0] a_in,
                                            input logic [15:0] b_in,
                                            input logic [3:0]  f);
    int a, b, sa, sb, s, ss, r, cy, ov;
    a = int'(a_in); b = int'(b_in);
    sa = to_signed(a); sb = to_signed(b);
    r = 0; cy = 0; ov = 0;
    case (alsu_op_e'(f))
      OP_ADD:   begin s = a + b; r = wrap16(s); cy = int'(s > 65535);
                      ss = sa + sb; ov = int'(ss > 32767 || ss < -32768); end
      OP_INC:   begin s = a + 1; r = wrap16(s); cy = int'(s > 65535);
                      ss = sa + 1; ov = int'(ss > 32767); end
      OP_SUB:   begin r = wrap16(a - b); cy = int'(a < b);
                      ss = sa - sb; ov = int'(ss > 32767 || ss < -32768); end
      OP_DEC:   begin r = wrap16(a - 1); cy = int'(a < 1);
                      ss = sa - 1; ov = int'(ss < -32768); end
      OP_NEG:   begin r = wrap16(0 - a); cy = int'(a != 0);
                      ss = 0 - sa; ov = int'(ss > 32767); end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = 65535 - a;
      OP_SHL:   begin r = (a * 2) % 65536; cy = a / 32768;
                      ov = int'(sa * 2 > 32767 || sa * 2 < -32768); end
      OP_SHR:   begin r = a / 2; cy = a % 2; end
      OP_SAR:   begin r = wrap16((sa >= 0) ? sa / 2 : -((1 - sa) / 2)); cy = a % 2; end
      OP_ROL:   begin r = (a * 2) % 65536 + a / 32768; cy = a / 32768; end
      OP_ROR:   begin r = a / 2 + (a % 2) * 32768; cy = a % 2; end
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default:  r = 0;
    endcase
    return {r[15:0], cy[0], ov[0]};
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = {Respuesta, Cy, Ov};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed={res,cy,ov}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    TuplaA  = a;
    TuplaB  = b;
    Funcion = f;
  endtask

  // One operation with a fixed expected value; also cross-checks the model.
  task automatic dir_step(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f, input logic [17:0] exp);
    drive(a, b, f);
    @(posedge clk); #1;
    check(tag, exp);
    check({tag, "_model"}, ref_model(a, b, f));
  endtask

  logic [15:0] sweep_res [16];
  logic [15:0] sweep_cy;

  initial begin
    sweep_res = '{16'h0008, 16'h0006, 16'h0008, 16'h0006, 16'h0001, 16'h0007, 16'h0006, 16'hFFF8,
                  16'h000E, 16'h0003, 16'h0003, 16'h000E, 16'h8003, 16'hFFF9, 16'h0007, 16'h0001};
    sweep_cy  = 16'b0011_0110_0000_0000;  // bits 9 (SHR), A (SAR), C (ROR), D (NEG)

    // Reset holds outputs at zero regardless of inputs.
    rst_n = 1'b0;
    drive(16'hFFFF, 16'h0001, OP_ADD);
    @(posedge clk); #1;
    check("reset_first", 18'h0);
    drive(16'h7FFF, 16'h0001, OP_ADD);
    @(posedge clk); #1;
    check("reset_held", 18'h0);
    rst_n = 1'b1;

    dir_step("add_ffff_1", 16'hFFFF, 16'h0001, OP_ADD, {16'h0000, 1'b1, 1'b0});
    dir_step("sub_ffff_1", 16'hFFFF, 16'h0001, OP_SUB, {16'hFFFE, 1'b0, 1'b0});
    dir_step("add_7fff_1", 16'h7FFF, 16'h0001, OP_ADD, {16'h8000, 1'b0, 1'b1});
    dir_step("sub_8000_1", 16'h8000, 16'h0001, OP_SUB, {16'h7FFF, 1'b0, 1'b1});
    dir_step("sub_borrow", 16'h0001, 16'h0002, OP_SUB, {16'hFFFF, 1'b1, 1'b0});
    dir_step("neg_8000",   16'h8000, 16'h1234, OP_NEG, {16'h8000, 1'b1, 1'b1});
    dir_step("neg_zero",   16'h0000, 16'hFFFF, OP_NEG, {16'h0000, 1'b0, 1'b0});
    dir_step("inc_7fff",   16'h7FFF, 16'hAAAA, OP_INC, {16'h8000, 1'b0, 1'b1});
    dir_step("dec_8000",   16'h8000, 16'h5555, OP_DEC, {16'h7FFF, 1'b0, 1'b1});
    dir_step("dec_zero",   16'h0000, 16'h5555, OP_DEC, {16'hFFFF, 1'b1, 1'b0});
    dir_step("shl_8001",   16'h8001, 16'h0000, OP_SHL, {16'h0002, 1'b1, 1'b1});
    dir_step("sar_8001",   16'h8001, 16'h0000, OP_SAR, {16'hC000, 1'b1, 1'b0});
    dir_step("rol_8001",   16'h8001, 16'h0000, OP_ROL, {16'h0003, 1'b1, 1'b0});
    dir_step("shr_8001",   16'h8001, 16'h0000, OP_SHR, {16'h4000, 1'b1, 1'b0});
    dir_step("ror_8001",   16'h8001, 16'h0000, OP_ROR, {16'hC000, 1'b1, 1'b0});

    // Opcode sweep with a new opcode every cycle.
    for (int f = 0; f < 16; f++) begin
      dir_step($sformatf("sweep_op%0h", f), 16'h0007, 16'h0001, 4'(f),
               {sweep_res[f], sweep_cy[f], 1'b0});
    end

    // Reset in the middle of back-to-back ADDs.
    dir_step("pre_reset_add", 16'h1234, 16'h1111, OP_ADD, {16'h2345, 1'b0, 1'b0});
    drive(16'h7FFF, 16'h0001, OP_ADD);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrun_reset", 18'h0);
    rst_n = 1'b1;
    dir_step("post_reset_add", 16'h7FFF, 16'h0001, OP_ADD, {16'h8000, 1'b0, 1'b1});

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] a, b;
      logic [3:0]  f;
      a = 16'($urandom);
      b = 16'($urandom);
      f = 4'($urandom_range(0, 15));
      drive(a, b, f);
      @(posedge clk); #1;
      check($sformatf("rand_%0d_op%0h_a%h_b%h", i, f, a, b), ref_model(a, b, f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
